// File: rtl/imm_extend_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | imm_extend_pipe: registered immediate extender with a 2-entry skid buffer. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       out_mode
);

  localparam int EXT_W = OUT_W - IN_W;

  logic [OUT_W-1:0] sign_ext;
  logic [OUT_W-1:0] ext_data;

  logic             m_valid_q, m_valid_d;
  logic [OUT_W-1:0] m_data_q,  m_data_d;
  logic [1:0]       m_mode_q,  m_mode_d;
  logic             s_valid_q, s_valid_d;
  logic [OUT_W-1:0] s_data_q,  s_data_d;
  logic [1:0]       s_mode_q,  s_mode_d;
  logic             in_ready_q, in_ready_d;

  logic accept;

  always_comb begin
    sign_ext = {{EXT_W{in_imm[IN_W-1]}}, in_imm};
    case (in_mode)
      2'd0:    ext_data = sign_ext;
      2'd1:    ext_data = {{EXT_W{1'b0}}, in_imm};
      2'd2:    ext_data = {in_imm, {EXT_W{1'b0}}};
      default: ext_data = {sign_ext[OUT_W-3:0], 2'b00};
    endcase
  end

  assign accept = in_valid && in_ready_q;

  always_comb begin
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    m_mode_d   = m_mode_q;
    s_valid_d  = s_valid_q;
    s_data_d   = s_data_q;
    s_mode_d   = s_mode_q;
    if (flush) begin
      // Data registers keep their last value; only the occupancy is cleared.
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (s_valid_q) begin
      // in_ready is low whenever S is occupied, so no accept can coincide here.
      if (out_ready) begin
        m_valid_d = 1'b1;
        m_data_d  = s_data_q;
        m_mode_d  = s_mode_q;
        s_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!m_valid_q || out_ready) begin
        m_valid_d = 1'b1;
        m_data_d  = ext_data;
        m_mode_d  = in_mode;
      end else begin
        s_valid_d = 1'b1;
        s_data_d  = ext_data;
        s_mode_d  = in_mode;
      end
    end else if (m_valid_q && out_ready) begin
      m_valid_d = 1'b0;
    end
    in_ready_d = !s_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_mode_q   <= 2'd0;
      s_valid_q  <= 1'b0;
      s_data_q   <= '0;
      s_mode_q   <= 2'd0;
      in_ready_q <= 1'b1;
    end else begin
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_mode_q   <= m_mode_d;
      s_valid_q  <= s_valid_d;
      s_data_q   <= s_data_d;
      s_mode_q   <= s_mode_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = m_valid_q;
  assign out_data  = m_data_q;
  assign out_mode  = m_mode_q;

endmodule
`default_nettype wire
